// File: rtl/depth_window_monitor_pkg.sv
// Shared types and defaults for the depth window monitor.
package depth_mon_pkg;

   // Window sequencing states
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      REPORT = 2'd2
   } state_t;

   localparam int DEPTH_W_DEF = 8;
   localparam int WIN_LEN_DEF = 16;
   localparam int CNT_W_DEF   = $clog2(WIN_LEN_DEF + 1);

   // Report layout for the default configuration
   typedef struct packed {
      logic [DEPTH_W_DEF-1:0]           max;
      logic [DEPTH_W_DEF-1:0]           min;
      logic [DEPTH_W_DEF+CNT_W_DEF-1:0] sum;
      logic [CNT_W_DEF-1:0]             count;
      logic [CNT_W_DEF-1:0]             viol;
      logic                             alarm;
   } report_t;

endpackage

// File: rtl/depth_window_monitor_streak.sv
// Consecutive-violation streak counter with a sticky per-window alarm.
module depth_streak_detector #(
   parameter int STREAK_LEN = 3,
   parameter int CNT_W      = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             acc,
   input  logic             viol,
   output logic [CNT_W-1:0] streak,
   output logic             alarm
);

   localparam logic [CNT_W-1:0] SAT    = CNT_W'(STREAK_LEN);
   localparam logic [CNT_W-1:0] SAT_M1 = CNT_W'(STREAK_LEN - 1);

   // Count violations in a row on accepted samples; alarm latches until window clear
   always_ff @(posedge clk) begin
      if (!rst || clr) begin
         streak <= '0;
         alarm  <= 1'b0;
      end else if (acc) begin
         if (viol) begin
            if (streak != SAT)
               streak <= streak + CNT_W'(1);
            if (streak >= SAT_M1)
               alarm <= 1'b1;
         end else begin
            streak <= '0;
         end
      end
   end

endmodule

// File: rtl/depth_window_monitor.sv
// Windowed statistics over depth samples with threshold violation tracking.
// Optional averaging outputs (rpt_avg, rpt_partial) exist when DEPTH_MON_AVG_EN is defined.
module depth_window_monitor
   import depth_mon_pkg::*;
#(
   parameter int DEPTH_W    = DEPTH_W_DEF,
   parameter int WIN_LEN    = 16,
   parameter int STREAK_LEN = 3,
   parameter int CNT_W      = $clog2(WIN_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     depth_valid,
   input  logic [DEPTH_W-1:0]       depth_in,
   output logic                     depth_ready,
   input  logic [DEPTH_W-1:0]       threshold,
   input  logic                     flush,
   output logic                     rpt_valid,
   input  logic                     rpt_ready,
   output logic [DEPTH_W-1:0]       rpt_max,
   output logic [DEPTH_W-1:0]       rpt_min,
   output logic [DEPTH_W+CNT_W-1:0] rpt_sum,
   output logic [CNT_W-1:0]         rpt_count,
   output logic [CNT_W-1:0]         rpt_viol,
   output logic                     rpt_alarm,
`ifdef DEPTH_MON_AVG_EN
   output logic [DEPTH_W-1:0]       rpt_avg,
   output logic                     rpt_partial,
`endif
   output logic                     busy
);

   localparam int               SUM_W     = DEPTH_W + CNT_W;
   localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_LEN);
   localparam logic [CNT_W-1:0] STREAK_M1 = CNT_W'(STREAK_LEN - 1);
`ifdef DEPTH_MON_AVG_EN
   localparam int               LOG2_WIN  = $clog2(WIN_LEN);
`endif

   state_t             state;
   logic [DEPTH_W-1:0] max_reg, min_reg, thr_reg;
   logic [SUM_W-1:0]   sum_reg;
   logic [CNT_W-1:0]   count_reg, viol_reg;

   logic [DEPTH_W-1:0] max_next, min_next;
   logic [SUM_W-1:0]   sum_next;
   logic [CNT_W-1:0]   count_next, viol_next;

   logic               accept, viol_hit, close_win, win_clear, alarm_next;
   logic [CNT_W-1:0]   streak;
   logic               alarm;

   assign depth_ready = (state != REPORT);
   assign busy        = (state != IDLE);
   assign accept      = depth_valid && depth_ready;
   // The opening sample has no captured threshold yet, so it uses the live one
   assign viol_hit    = (state == IDLE) ? (depth_in > threshold) : (depth_in > thr_reg);
   assign win_clear   = rpt_valid && rpt_ready;
   // Alarm as it will stand after this cycle's sample, so the closing sample counts
   assign alarm_next  = alarm || (accept && viol_hit && (streak >= STREAK_M1));
   assign close_win   = (state == ACCUM) && (flush || (accept && (count_next == WIN_CNT)));

   depth_streak_detector #(
      .STREAK_LEN (STREAK_LEN),
      .CNT_W      (CNT_W)
   ) u_streak (
      .clk    (clk),
      .rst    (rst),
      .clr    (win_clear),
      .acc    (accept),
      .viol   (viol_hit),
      .streak (streak),
      .alarm  (alarm)
   );

   // Window accumulator update for the current sample
   always_comb begin
      max_next   = max_reg;
      min_next   = min_reg;
      sum_next   = sum_reg;
      count_next = count_reg;
      viol_next  = viol_reg;
      if (accept) begin
         if (state == IDLE) begin
            max_next   = depth_in;
            min_next   = depth_in;
            sum_next   = SUM_W'(depth_in);
            count_next = CNT_W'(1);
            viol_next  = viol_hit ? CNT_W'(1) : '0;
         end else begin
            max_next   = (depth_in > max_reg) ? depth_in : max_reg;
            min_next   = (depth_in < min_reg) ? depth_in : min_reg;
            sum_next   = sum_reg + SUM_W'(depth_in);
            count_next = count_reg + CNT_W'(1);
            viol_next  = viol_reg + CNT_W'(viol_hit);
         end
      end
   end

   // Window FSM with accumulators and registered report outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= IDLE;
         max_reg   <= '0;
         min_reg   <= '0;
         sum_reg   <= '0;
         count_reg <= '0;
         viol_reg  <= '0;
         thr_reg   <= '0;
         rpt_valid <= 1'b0;
         rpt_max   <= '0;
         rpt_min   <= '0;
         rpt_sum   <= '0;
         rpt_count <= '0;
         rpt_viol  <= '0;
         rpt_alarm <= 1'b0;
`ifdef DEPTH_MON_AVG_EN
         rpt_avg     <= '0;
         rpt_partial <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state     <= ACCUM;
                  thr_reg   <= threshold;
                  max_reg   <= max_next;
                  min_reg   <= min_next;
                  sum_reg   <= sum_next;
                  count_reg <= count_next;
                  viol_reg  <= viol_next;
               end
            end
            ACCUM: begin
               max_reg   <= max_next;
               min_reg   <= min_next;
               sum_reg   <= sum_next;
               count_reg <= count_next;
               viol_reg  <= viol_next;
               if (close_win) begin
                  state     <= REPORT;
                  rpt_valid <= 1'b1;
                  rpt_max   <= max_next;
                  rpt_min   <= min_next;
                  rpt_sum   <= sum_next;
                  rpt_count <= count_next;
                  rpt_viol  <= viol_next;
                  rpt_alarm <= alarm_next;
`ifdef DEPTH_MON_AVG_EN
                  rpt_avg     <= (count_next == WIN_CNT) ? DEPTH_W'(sum_next >> LOG2_WIN) : '0;
                  rpt_partial <= (count_next != WIN_CNT);
`endif
               end
            end
            REPORT: begin
               if (rpt_ready) begin
                  state     <= IDLE;
                  rpt_valid <= 1'b0;
                  max_reg   <= '0;
                  min_reg   <= '0;
                  sum_reg   <= '0;
                  count_reg <= '0;
                  viol_reg  <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_depth_window_monitor.sv
// Scoreboard bench for depth_window_monitor: directed scenarios plus random windows.
module tb_depth_window_monitor;

   localparam int DW = 8;
   localparam int WL = 4;
   localparam int SL = 3;
   localparam int CW = $clog2(WL + 1);
   localparam int SW = DW + CW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          depth_valid = 1'b0;
   logic [DW-1:0] depth_in = '0;
   logic          depth_ready;
   logic [DW-1:0] threshold = '0;
   logic          flush = 1'b0;
   logic          rpt_valid;
   logic          rpt_ready = 1'b0;
   logic [DW-1:0] rpt_max, rpt_min;
   logic [SW-1:0] rpt_sum;
   logic [CW-1:0] rpt_count, rpt_viol;
   logic          rpt_alarm;
`ifdef DEPTH_MON_AVG_EN
   logic [DW-1:0] rpt_avg;
   logic          rpt_partial;
`endif
   logic          busy;

   depth_window_monitor #(
      .DEPTH_W    (DW),
      .WIN_LEN    (WL),
      .STREAK_LEN (SL),
      .CNT_W      (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .depth_valid (depth_valid),
      .depth_in    (depth_in),
      .depth_ready (depth_ready),
      .threshold   (threshold),
      .flush       (flush),
      .rpt_valid   (rpt_valid),
      .rpt_ready   (rpt_ready),
      .rpt_max     (rpt_max),
      .rpt_min     (rpt_min),
      .rpt_sum     (rpt_sum),
      .rpt_count   (rpt_count),
      .rpt_viol    (rpt_viol),
      .rpt_alarm   (rpt_alarm),
`ifdef DEPTH_MON_AVG_EN
      .rpt_avg     (rpt_avg),
      .rpt_partial (rpt_partial),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int mx;
      int mn;
      int sm;
      int cnt;
      int vl;
      bit al;
      int avg;
      bit partial;
   } rpt_t;

   rpt_t exp_q[$];
   int   win[$];
   int   cap_thr = 0;
   int   tests = 0;
   int   fails = 0;
   bit   rdy_rand = 1'b0;
   bit   rdy_force = 1'b1;
   rpt_t mon_r;

   // Consumer-side ready: forced or random, updated after the stimulus settles
   always @(posedge clk) begin
      #2;
      rpt_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_force;
   end

   task automatic chk(input string name, input logic [63:0] act, input longint expv);
      tests++;
      if (act !== 64'(expv)) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   // Reference: statistics over the recorded window, streak = longest violation run
   function automatic void model_close();
      rpt_t r;
      int   run;
      r.mx = win[0];
      r.mn = win[0];
      r.sm = 0;
      r.vl = 0;
      r.al = 1'b0;
      run  = 0;
      foreach (win[i]) begin
         if (win[i] > r.mx) r.mx = win[i];
         if (win[i] < r.mn) r.mn = win[i];
         r.sm += win[i];
         if (win[i] > cap_thr) begin
            r.vl++;
            run++;
            if (run >= SL) r.al = 1'b1;
         end else begin
            run = 0;
         end
      end
      r.cnt     = win.size();
      r.partial = (r.cnt < WL);
      r.avg     = r.partial ? 0 : r.sm / WL;
      exp_q.push_back(r);
      win.delete();
   endfunction

   function automatic void model_accept(input int d, input bit fl);
      bit was_open;
      was_open = (win.size() > 0);
      if (!was_open) cap_thr = threshold;
      win.push_back(d);
      if (win.size() == WL || (fl && was_open)) model_close();
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int d, input bit fl);
      bit ok;
      int guard;
      ok    = 1'b0;
      guard = 0;
      depth_valid = 1'b1;
      depth_in    = DW'(d);
      flush       = fl;
      while (!ok) begin
         @(negedge clk);
         ok = depth_ready;
         @(posedge clk);
         #1;
         if (!ok) begin
            guard++;
            if (guard > 100) begin
               tests++;
               fails++;
               $display("FAIL send_timeout: got depth_ready 0 for %0d cycles expected acceptance", guard);
               break;
            end
         end
      end
      if (ok) model_accept(d, fl);
      depth_valid = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic flush_only();
      flush = 1'b1;
      cyc(1);
      flush = 1'b0;
      if (win.size() > 0) model_close();
   endtask

   task automatic wait_drain();
      int guard;
      guard = 0;
      while (exp_q.size() > 0 && guard < 200) begin
         cyc(1);
         guard++;
      end
      if (exp_q.size() > 0) begin
         tests++;
         fails++;
         $display("FAIL drain_timeout: got %0d reports outstanding expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Monitor: every handshake pops one expected report; valid with nothing expected is an error
   always @(negedge clk) begin
      if (rst && rpt_valid) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL spurious_report: got rpt_valid 1 expected 0 (max %0d sum %0d count %0d)",
                     rpt_max, rpt_sum, rpt_count);
         end else if (rpt_ready) begin
            mon_r = exp_q.pop_front();
            tests++;
            if (rpt_max !== DW'(mon_r.mx) || rpt_min !== DW'(mon_r.mn) || rpt_sum !== SW'(mon_r.sm) ||
                rpt_count !== CW'(mon_r.cnt) || rpt_viol !== CW'(mon_r.vl) || rpt_alarm !== mon_r.al
`ifdef DEPTH_MON_AVG_EN
                || rpt_avg !== DW'(mon_r.avg) || rpt_partial !== mon_r.partial
`endif
               ) begin
               fails++;
               $display("FAIL report: got max %0d min %0d sum %0d cnt %0d viol %0d alarm %0d expected max %0d min %0d sum %0d cnt %0d viol %0d alarm %0d",
                        rpt_max, rpt_min, rpt_sum, rpt_count, rpt_viol, rpt_alarm,
                        mon_r.mx, mon_r.mn, mon_r.sm, mon_r.cnt, mon_r.vl, mon_r.al);
            end else begin
               $display("[TB] report max %0d min %0d sum %0d cnt %0d viol %0d alarm %0d ok",
                        rpt_max, rpt_min, rpt_sum, rpt_count, rpt_viol, rpt_alarm);
            end
         end
      end
   end

   initial begin
      int d;
      // Reset state
      rst = 1'b0;
      cyc(3);
      chk("reset_rpt_valid", rpt_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_depth_ready", depth_ready, 1);
      chk("reset_rpt_max", rpt_max, 0);
      chk("reset_rpt_min", rpt_min, 0);
      chk("reset_rpt_sum", rpt_sum, 0);
      chk("reset_rpt_count", rpt_count, 0);
      chk("reset_rpt_viol", rpt_viol, 0);
      chk("reset_rpt_alarm", rpt_alarm, 0);
      rst = 1'b1;
      cyc(2);

      // Full window, back-to-back, with latency checks
      rdy_force = 1'b1;
      threshold = 8'd5;
      send(3, 0);
      chk("busy_in_window", busy, 1);
      send(7, 0);
      send(2, 0);
      chk("latency_before_close", rpt_valid, 0);
      send(9, 0);
      chk("latency_at_close", rpt_valid, 1);
      wait_drain();

      // Streak alarm, then equality is not a violation
      send(6, 0); send(7, 0); send(8, 0); send(1, 0);
      send(5, 0); send(5, 0); send(5, 0); send(5, 0);
      wait_drain();

      // Backpressure: report held, no acceptance until handshake
      rdy_force = 1'b0;
      cyc(1);
      send(1, 0); send(2, 0); send(3, 0); send(4, 0);
      depth_valid = 1'b1;
      depth_in    = 8'd11;
      repeat (10) begin
         @(negedge clk);
         chk("bp_depth_ready", depth_ready, 0);
         chk("bp_rpt_valid", rpt_valid, 1);
         if (exp_q.size() > 0) begin
            chk("bp_rpt_sum", rpt_sum, exp_q[0].sm);
            chk("bp_rpt_max", rpt_max, exp_q[0].mx);
         end
         @(posedge clk);
         #1;
      end
      rdy_force = 1'b1;
      @(negedge clk);
      chk("bp_handshake_ready", depth_ready, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("post_hs_ready", depth_ready, 1);
      chk("post_hs_busy", busy, 0);
      @(posedge clk);
      #1;
      model_accept(11, 0);
      depth_valid = 1'b0;
      send(12, 0); send(0, 0); send(255, 0);
      wait_drain();

      // Flush with simultaneous sample, flush alone, flush while idle
      send(4, 0); send(10, 0); send(1, 1);
      wait_drain();
      send(20, 0); send(30, 0);
      flush_only();
      wait_drain();
      flush_only();
      cyc(2);
      chk("idle_flush_busy", busy, 0);
      chk("idle_flush_valid", rpt_valid, 0);

      // Reset mid-window discards partial data
      send(100, 0); send(200, 0);
      rst = 1'b0;
      win.delete();
      cyc(1);
      chk("midrst_busy", busy, 0);
      chk("midrst_valid", rpt_valid, 0);
      chk("midrst_ready", depth_ready, 1);
      rst = 1'b1;
      cyc(1);
      send(1, 0); send(2, 0); send(3, 0); send(4, 0);
      wait_drain();

      // Threshold captured at window start
      threshold = 8'd5;
      send(6, 0);
      threshold = 8'd0;
      send(3, 0); send(7, 0); send(2, 0);
      wait_drain();

      // Random windows with random consumer stalls
      rdy_rand = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if ($urandom_range(0, 7) == 0)
            threshold = ($urandom_range(0, 9) == 0) ? 8'd255 : DW'($urandom_range(0, 15));
         case ($urandom_range(0, 9))
            0:       d = 0;
            1:       d = 255;
            default: d = $urandom_range(0, 15);
         endcase
         send(d, ($urandom_range(0, 9) == 0));
         if ($urandom_range(0, 4) == 0) cyc($urandom_range(1, 2));
         if ($urandom_range(0, 19) == 0) flush_only();
      end
      rdy_rand  = 1'b0;
      rdy_force = 1'b1;
      cyc(2);
      flush_only();
      wait_drain();
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/depth_window_monitor.md
Name: depth_window_monitor

Overview:
- Downstream consumer of the logic-depth analyzer's 8-bit `depth` result.
- Collects depth samples over a fixed-length window and checks each sample against a programmable threshold.
- Produces one report per window with max, min, sum, sample count, violation count and a consecutive-violation alarm.
- Reports are held on a valid/ready handshake so the results writer can stall the block.

Parameters:
- DEPTH_W, 8, width of depth samples and threshold
- WIN_LEN, 16, samples per full window; must be a power of two, ≥2
- STREAK_LEN, 3, consecutive violations that raise the alarm; range 1..WIN_LEN
- CNT_W, $clog2(WIN_LEN+1), width of sample and violation counters (derived)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low
- depth_valid  in  1  sample present
- depth_in  in  DEPTH_W  depth sample
- depth_ready  out  1  block can accept a sample
- threshold  in  DEPTH_W  violation threshold; captured on the first sample of each window
- flush  in  1  single-cycle pulse that closes a partial window
- rpt_valid  out  1  report available
- rpt_ready  in  1  report consumed
- rpt_max  out  DEPTH_W  largest sample in window
- rpt_min  out  DEPTH_W  smallest sample in window
- rpt_sum  out  DEPTH_W+CNT_W  sum of samples
- rpt_count  out  CNT_W  samples in window
- rpt_viol  out  CNT_W  samples with depth_in > threshold
- rpt_alarm  out  1  a streak of ≥STREAK_LEN consecutive violations occurred in the window
- busy  out  1  state != IDLE

Behaviour:
- Reset: applied when rst==0 at a clk edge.
  - State goes to IDLE; all accumulators clear.
  - Outputs after reset: rpt_valid=0, rpt_max/min/sum/count/viol=0, rpt_alarm=0, busy=0, depth_ready=1.
  - Reset asserted mid-window or mid-report discards all pending data; no report is emitted.
- Sample acceptance: a sample is accepted when depth_valid && depth_ready. depth_ready=1 in IDLE and ACCUM, 0 in REPORT.
- FSM IDLE:
  - An accepted sample moves the block to ACCUM.
  - That sample initialises the window: max=min=sum=depth_in, count=1.
  - threshold is registered as thr_q, and the sample is compared against the live threshold value.
  - If WIN_LEN==... is not applicable (WIN_LEN≥2), so this state never jumps straight to REPORT.
- FSM ACCUM:
  - Each accepted sample updates max and min, adds to sum and increments count.
  - Violation test: depth_in > thr_q, strictly greater; equality is not a violation.
  - On a violation, viol increments and streak increments, saturating at STREAK_LEN.
  - A non-violating sample clears streak to 0.
  - alarm sets when streak reaches STREAK_LEN and stays set for the rest of the window.
  - When count reaches WIN_LEN on an accepted sample, go to REPORT on the next edge.
- Flush:
  - A flush in ACCUM, with or without a simultaneous sample, goes to REPORT; a simultaneous sample is included first.
  - Flush in IDLE or REPORT is ignored.
- FSM REPORT:
  - rpt_* outputs are registered copies of the window results, stable while rpt_valid=1.
  - rpt_valid rises one cycle after the closing sample or flush.
  - When rpt_valid && rpt_ready, the next state is IDLE, rpt_valid drops and accumulators clear.
  - The following sample is accepted no earlier than the cycle after the handshake; there is no bypass.
- Arithmetic: rpt_sum cannot overflow by construction (DEPTH_W+CNT_W bits), so there is no wrap. Counters never exceed WIN_LEN.
- Latency: a full window at one sample per cycle gives rpt_valid in cycle WIN_LEN+1 after the first accept.

Optional Feature:
- Macro: DEPTH_MON_AVG_EN.
- With the macro defined:
  - Adds output rpt_avg [DEPTH_W] = rpt_sum >> log2(WIN_LEN) (truncating) for full windows.
  - For flushed partial windows, rpt_avg = 0 and the additional output rpt_partial=1.
- Without the macro: neither port exists and no averaging logic is built.

Decomposition:
- Shared package depth_mon_pkg:
  - state enum {IDLE, ACCUM, REPORT}
  - DEPTH_W default constant
  - report struct {max, min, sum, count, viol, alarm}
- Natural sub-module: depth_streak_detector. It takes the violation strobe, sample-accept strobe and a window-clear input, and outputs the saturating streak count and sticky alarm.

Test Plan:
- Full window: WIN_LEN=4, STREAK_LEN=3, threshold=5, samples 3,7,2,9 back-to-back, rpt_ready=1 → rpt_max=9, min=2, sum=21, count=4, viol=2, alarm=0; rpt_valid pulses in cycle 5.
- Streak alarm: threshold=5, samples 6,7,8,1 → viol=3, alarm=1. Then a second window 5,5,5,5 → viol=0 (equality), alarm=0.
- Backpressure: hold rpt_ready=0 for 10 cycles with depth_valid=1 → depth_ready=0, report fields constant. Release → handshake, IDLE, next sample accepted the following cycle.
- Flush: samples 4,10 then flush with simultaneous sample 1 → count=3, sum=15, max=10, min=1. With DEPTH_MON_AVG_EN → rpt_partial=1, rpt_avg=0.
- Reset mid-window: 2 samples accepted, then rst=0 for 1 cycle → busy=0, rpt_valid=0, no report. A new 4-sample window reports only its own data.
- Threshold capture: threshold changed from 5 to 0 mid-window → violations are still judged against 5 until the next window.
